// File: rtl/nios2_dbg_cmd_dispatch_if.sv
// Command bus between the debug command dispatcher (master) and the OCI consumer (slave).
// cmd_ts exists only when DBG_CMD_TIMESTAMP_EN is defined.
interface nios2_dbg_cmd_dispatch_if #(
   parameter int SR_W = 38,
   parameter int IR_W = 2
);
   localparam int NCMD = 2 ** IR_W;

   logic [SR_W-1:0] jdo;
   logic [IR_W-1:0] cmd_ir;
   logic            cmd_valid;
   logic            cmd_ready;
   logic [NCMD-1:0] take_action;
   logic [NCMD-1:0] take_no_action;
`ifdef DBG_CMD_TIMESTAMP_EN
   logic [15:0]     cmd_ts;
`endif

   modport master (
      output jdo, cmd_ir, cmd_valid, take_action, take_no_action,
`ifdef DBG_CMD_TIMESTAMP_EN
      output cmd_ts,
`endif
      input  cmd_ready
   );

   modport slave (
      input  jdo, cmd_ir, cmd_valid, take_action, take_no_action,
`ifdef DBG_CMD_TIMESTAMP_EN
      input  cmd_ts,
`endif
      output cmd_ready
   );
endinterface

// File: rtl/nios2_dbg_cmd_dispatch.sv
// System-clock half of the Nios II JTAG debug slave: strobe sync, command FIFO, dispatch.
// Optional macro DBG_CMD_TIMESTAMP_EN adds a 16-bit push timestamp (cmd_ts) to each command.
module nios2_dbg_cmd_dispatch #(
   parameter int SR_W        = 38,
   parameter int IR_W        = 2,
   parameter int ACT_BIT     = 35,
   parameter int SYNC_STAGES = 2,
   parameter int FIFO_DEPTH  = 4
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic [IR_W-1:0] ir_in,
   input  logic [SR_W-1:0] sr,
   input  logic            vs_uir,
   input  logic            vs_udr,
   input  logic            ovf_clr,
   output logic            cmd_pending,
   output logic            ovf,
   nios2_dbg_cmd_dispatch_if.master cmd_if
);
   localparam int NCMD = 2 ** IR_W;
   localparam int PW   = $clog2(FIFO_DEPTH);
   localparam int CW   = PW + 1;

   function automatic logic [NCMD-1:0] onehot_f(input logic [IR_W-1:0] idx);
      logic [NCMD-1:0] v;
      v      = {NCMD{1'b0}};
      v[idx] = 1'b1;
      return v;
   endfunction

   logic [SYNC_STAGES-1:0] uir_sync_r, udr_sync_r;
   logic                   uir_prev_r, udr_prev_r;
   logic [IR_W-1:0]        ir_reg_r;

   logic [SR_W-1:0]        mem_sr_r [FIFO_DEPTH];
   logic [IR_W-1:0]        mem_ir_r [FIFO_DEPTH];
   logic [PW-1:0]          wr_ptr_r, rd_ptr_r;
   logic [CW-1:0]          count_r;
   logic                   pending_r, ovf_r;

   logic [SR_W-1:0]        jdo_r;
   logic [IR_W-1:0]        cmd_ir_r;
   logic                   valid_r;
   logic [NCMD-1:0]        take_action_r, take_no_action_r;

   logic                   uir_rise_s, udr_rise_s, full_s, pop_s, push_s, drop_s;
   logic [IR_W-1:0]        push_ir_s;
   logic [CW-1:0]          count_nxt_s;
   logic [SR_W-1:0]        rd_sr_s;
   logic [IR_W-1:0]        rd_ir_s;

`ifdef DBG_CMD_TIMESTAMP_EN
   logic [15:0]            ts_r;
   logic [15:0]            cmd_ts_r;
   logic [15:0]            mem_ts_r [FIFO_DEPTH];
`endif

   // Strobe synchronisers and edge history; history starts at 0 so a level already high at release still yields one edge.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         uir_sync_r <= {SYNC_STAGES{1'b0}};
         udr_sync_r <= {SYNC_STAGES{1'b0}};
         uir_prev_r <= 1'b0;
         udr_prev_r <= 1'b0;
      end else begin
         uir_sync_r <= {uir_sync_r[SYNC_STAGES-2:0], vs_uir};
         udr_sync_r <= {udr_sync_r[SYNC_STAGES-2:0], vs_udr};
         uir_prev_r <= uir_sync_r[SYNC_STAGES-1];
         udr_prev_r <= udr_sync_r[SYNC_STAGES-1];
      end
   end

   // Edge detect, push/pop/drop arbitration and next FIFO occupancy.
   always_comb begin
      uir_rise_s = uir_sync_r[SYNC_STAGES-1] & ~uir_prev_r;
      udr_rise_s = udr_sync_r[SYNC_STAGES-1] & ~udr_prev_r;
      full_s     = (count_r == CW'(FIFO_DEPTH));
      pop_s      = (count_r != {CW{1'b0}}) & (~valid_r | cmd_if.cmd_ready);
      push_ir_s  = uir_rise_s ? ir_in : ir_reg_r;
      push_s     = 1'b0;
      drop_s     = 1'b0;
      if (udr_rise_s) begin
         if (full_s && !pop_s) begin
            drop_s = 1'b1;
         end else begin
            push_s = 1'b1;
         end
      end else begin
         push_s = 1'b0;
      end
      case ({push_s, pop_s})
         2'b10:   count_nxt_s = count_r + CW'(1);
         2'b01:   count_nxt_s = count_r - CW'(1);
         default: count_nxt_s = count_r;
      endcase
      rd_sr_s = mem_sr_r[rd_ptr_r];
      rd_ir_s = mem_ir_r[rd_ptr_r];
   end

   // FIFO storage; contents are only meaningful between the pointers, so no reset.
   always_ff @(posedge clk) begin
      if (push_s) begin
         mem_sr_r[wr_ptr_r] <= sr;
         mem_ir_r[wr_ptr_r] <= push_ir_s;
`ifdef DBG_CMD_TIMESTAMP_EN
         mem_ts_r[wr_ptr_r] <= ts_r;
`endif
      end
   end

   // IR capture, FIFO pointers/count, pending and sticky overflow.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ir_reg_r  <= {IR_W{1'b0}};
         wr_ptr_r  <= {PW{1'b0}};
         rd_ptr_r  <= {PW{1'b0}};
         count_r   <= {CW{1'b0}};
         pending_r <= 1'b0;
         ovf_r     <= 1'b0;
      end else begin
         if (uir_rise_s) begin
            ir_reg_r <= ir_in;
         end
         if (push_s) begin
            wr_ptr_r <= wr_ptr_r + PW'(1);
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + PW'(1);
         end
         count_r   <= count_nxt_s;
         pending_r <= (count_nxt_s != {CW{1'b0}});
         if (drop_s) begin
            ovf_r <= 1'b1;
         end else if (ovf_clr) begin
            ovf_r <= 1'b0;
         end
      end
   end

   // Output register: load on pop with a one-cycle decoded pulse; otherwise retire on acceptance.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         jdo_r            <= {SR_W{1'b0}};
         cmd_ir_r         <= {IR_W{1'b0}};
         valid_r          <= 1'b0;
         take_action_r    <= {NCMD{1'b0}};
         take_no_action_r <= {NCMD{1'b0}};
`ifdef DBG_CMD_TIMESTAMP_EN
         cmd_ts_r         <= 16'h0000;
`endif
      end else if (pop_s) begin
         jdo_r            <= rd_sr_s;
         cmd_ir_r         <= rd_ir_s;
         valid_r          <= 1'b1;
         take_action_r    <= rd_sr_s[ACT_BIT] ? onehot_f(rd_ir_s) : {NCMD{1'b0}};
         take_no_action_r <= rd_sr_s[ACT_BIT] ? {NCMD{1'b0}} : onehot_f(rd_ir_s);
`ifdef DBG_CMD_TIMESTAMP_EN
         cmd_ts_r         <= mem_ts_r[rd_ptr_r];
`endif
      end else begin
         take_action_r    <= {NCMD{1'b0}};
         take_no_action_r <= {NCMD{1'b0}};
         if (cmd_if.cmd_ready) begin
            valid_r <= 1'b0;
         end
      end
   end

`ifdef DBG_CMD_TIMESTAMP_EN
   // Free-running push timestamp.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ts_r <= 16'h0000;
      end else begin
         ts_r <= ts_r + 16'h0001;
      end
   end

   assign cmd_if.cmd_ts = cmd_ts_r;
`endif

   assign cmd_if.jdo            = jdo_r;
   assign cmd_if.cmd_ir         = cmd_ir_r;
   assign cmd_if.cmd_valid      = valid_r;
   assign cmd_if.take_action    = take_action_r;
   assign cmd_if.take_no_action = take_no_action_r;
   assign cmd_pending           = pending_r;
   assign ovf                   = ovf_r;

endmodule

// File: tb/tb_nios2_dbg_cmd_dispatch.sv
// Bench for nios2_dbg_cmd_dispatch: directed scenarios plus random strobes against a queue-level model.
module tb_nios2_dbg_cmd_dispatch;
   localparam int SR_W    = 38;
   localparam int IR_W    = 2;
   localparam int ACT_BIT = 35;
   localparam int S       = 2;
   localparam int D       = 4;
   localparam int NCMD    = 4;

   logic            clk = 1'b0;
   logic            reset_n;
   logic [IR_W-1:0] ir_in;
   logic [SR_W-1:0] sr;
   logic            vs_uir, vs_udr, ovf_clr;
   logic            cmd_pending, ovf;

   nios2_dbg_cmd_dispatch_if #(.SR_W(SR_W), .IR_W(IR_W)) cmd_if ();

   nios2_dbg_cmd_dispatch #(
      .SR_W(SR_W), .IR_W(IR_W), .ACT_BIT(ACT_BIT), .SYNC_STAGES(S), .FIFO_DEPTH(D)
   ) dut (
      .clk(clk), .reset_n(reset_n), .ir_in(ir_in), .sr(sr),
      .vs_uir(vs_uir), .vs_udr(vs_udr), .ovf_clr(ovf_clr),
      .cmd_pending(cmd_pending), .ovf(ovf), .cmd_if(cmd_if.master)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [IR_W-1:0] ir;
      logic [SR_W-1:0] sr;
      logic [15:0]     ts;
   } ent_t;

   ent_t            q[$];
   bit              uir_h[S+1];
   bit              udr_h[S+1];
   logic            m_valid, m_ovf, m_pending;
   logic [SR_W-1:0] m_jdo;
   logic [IR_W-1:0] m_ir, m_ir_reg;
   logic [NCMD-1:0] m_ta, m_tna;
   logic [15:0]     m_ts_cnt, m_cmd_ts;
   int              n_cmp = 0;
   int              n_err = 0;
   int              pulse_cnt = 0;

   task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic void model_reset();
      q.delete();
      for (int i = 0; i <= S; i++) begin
         uir_h[i] = 1'b0;
         udr_h[i] = 1'b0;
      end
      m_valid = 1'b0; m_ovf = 1'b0; m_pending = 1'b0;
      m_jdo = '0; m_ir = '0; m_ir_reg = '0; m_ta = '0; m_tna = '0;
      m_ts_cnt = 16'h0; m_cmd_ts = 16'h0;
   endfunction

   // One clock edge of the reference model, using the inputs the DUT sampled.
   function automatic void model_edge();
      bit   uir_rise, udr_rise, pop, drop;
      ent_t e;
      logic [NCMD-1:0] one;
      if (!reset_n) begin
         model_reset();
         return;
      end
      one      = 1;
      uir_rise = uir_h[S-1] & ~uir_h[S];
      udr_rise = udr_h[S-1] & ~udr_h[S];
      for (int i = S; i > 0; i--) begin
         uir_h[i] = uir_h[i-1];
         udr_h[i] = udr_h[i-1];
      end
      uir_h[0] = vs_uir;
      udr_h[0] = vs_udr;

      pop  = (q.size() != 0) && (!m_valid || cmd_if.cmd_ready);
      drop = 1'b0;
      if (pop) begin
         e        = q.pop_front();
         m_jdo    = e.sr;
         m_ir     = e.ir;
         m_cmd_ts = e.ts;
         m_valid  = 1'b1;
         m_ta     = e.sr[ACT_BIT] ? (one << e.ir) : '0;
         m_tna    = e.sr[ACT_BIT] ? '0 : (one << e.ir);
      end else begin
         m_ta  = '0;
         m_tna = '0;
         if (cmd_if.cmd_ready) m_valid = 1'b0;
      end
      if (udr_rise) begin
         if (q.size() < D) begin
            e.ir = uir_rise ? ir_in : m_ir_reg;
            e.sr = sr;
            e.ts = m_ts_cnt;
            q.push_back(e);
         end else begin
            drop = 1'b1;
         end
      end
      if (drop) m_ovf = 1'b1;
      else if (ovf_clr) m_ovf = 1'b0;
      if (uir_rise) m_ir_reg = ir_in;
      m_ts_cnt  = m_ts_cnt + 16'h1;
      m_pending = (q.size() != 0);
   endfunction

   task automatic compare_all();
      check_val("cmd_valid", cmd_if.cmd_valid, m_valid);
      check_val("jdo", cmd_if.jdo, m_jdo);
      check_val("cmd_ir", cmd_if.cmd_ir, m_ir);
      check_val("take_action", cmd_if.take_action, m_ta);
      check_val("take_no_action", cmd_if.take_no_action, m_tna);
      check_val("cmd_pending", cmd_pending, m_pending);
      check_val("ovf", ovf, m_ovf);
`ifdef DBG_CMD_TIMESTAMP_EN
      check_val("cmd_ts", cmd_if.cmd_ts, m_cmd_ts);
`endif
   endtask

   task automatic tick();
      @(posedge clk);
      model_edge();
      #1;
      compare_all();
      if ((cmd_if.take_action | cmd_if.take_no_action) != '0) pulse_cnt++;
   endtask

   task automatic ir_scan(input logic [IR_W-1:0] v);
      ir_in  = v;
      vs_uir = 1'b1;
      repeat (S + 3) tick();
      vs_uir = 1'b0;
      repeat (2) tick();
   endtask

   task automatic dr_scan(input logic [SR_W-1:0] v);
      sr     = v;
      vs_udr = 1'b1;
      repeat (S + 3) tick();
      vs_udr = 1'b0;
      repeat (2) tick();
   endtask

   initial begin
      int lat;
      reset_n = 1'b0; ir_in = '0; sr = '0; vs_uir = 1'b0; vs_udr = 1'b0; ovf_clr = 1'b0;
      cmd_if.cmd_ready = 1'b1;
      model_reset();
      repeat (3) tick();
      check_val("reset_valid", cmd_if.cmd_valid, 1'b0);
      check_val("reset_jdo", cmd_if.jdo, 38'h0);
      reset_n = 1'b1;
      tick();

      // Action command under IR 1, with latency measured from the first udr sample.
      ir_scan(2'b01);
      sr = 38'h08_0000_1234;
      vs_udr = 1'b1;
      repeat (3) tick();
      check_val("lat_edge3_valid", cmd_if.cmd_valid, 1'b0);
      tick();
      check_val("lat_edge4_valid", cmd_if.cmd_valid, 1'b1);
      check_val("act_jdo", cmd_if.jdo, 38'h08_0000_1234);
      check_val("act_ir", cmd_if.cmd_ir, 2'd1);
      check_val("act_pulse", cmd_if.take_action, 4'b0010);
      check_val("act_nopulse", cmd_if.take_no_action, 4'b0000);
      tick();
      check_val("act_pulse_end", cmd_if.take_action, 4'b0000);
      vs_udr = 1'b0;
      repeat (2) tick();

      // No-action command under IR 3.
      ir_scan(2'b11);
      pulse_cnt = 0;
      dr_scan(38'h30_0000_0055);
      check_val("noact_ir", cmd_if.cmd_ir, 2'd3);
      check_val("noact_pulses", pulse_cnt, 1);

      // Fill and overflow with the consumer stalled.
      cmd_if.cmd_ready = 1'b0;
      for (int i = 1; i <= 5; i++) dr_scan(SR_W'(i));
      check_val("fill_jdo", cmd_if.jdo, 38'h1);
      check_val("fill_ovf", ovf, 1'b0);
      check_val("fill_pending", cmd_pending, 1'b1);
      dr_scan(38'h6);
      check_val("drop_ovf", ovf, 1'b1);
      cmd_if.cmd_ready = 1'b1;
      repeat (8) tick();
      check_val("drain_jdo", cmd_if.jdo, 38'h5);
      check_val("drain_pending", cmd_pending, 1'b0);
      ovf_clr = 1'b1;
      tick();
      ovf_clr = 1'b0;
      check_val("ovf_clr", ovf, 1'b0);

      // Stalled output stays stable with a single pulse.
      cmd_if.cmd_ready = 1'b0;
      pulse_cnt = 0;
      dr_scan(38'h7);
      repeat (10) tick();
      check_val("hold_pulses", pulse_cnt, 1);
      check_val("hold_valid", cmd_if.cmd_valid, 1'b1);
      check_val("hold_jdo", cmd_if.jdo, 38'h7);

      // Full FIFO: push coinciding with an accept.
      for (int i = 8; i <= 11; i++) dr_scan(SR_W'(i));
      sr = 38'hC;
      vs_udr = 1'b1;
      repeat (2) tick();
      cmd_if.cmd_ready = 1'b1;
      tick();
      cmd_if.cmd_ready = 1'b0;
      check_val("full_pp_ovf", ovf, 1'b0);
      check_val("full_pp_jdo", cmd_if.jdo, 38'h8);
      vs_udr = 1'b0;
      repeat (3) tick();
      cmd_if.cmd_ready = 1'b1;
      repeat (10) tick();
      check_val("full_pp_last", cmd_if.jdo, 38'hC);

      // Reset with entries queued and udr held high.
      cmd_if.cmd_ready = 1'b0;
      for (int i = 13; i <= 16; i++) dr_scan(SR_W'(i));
      vs_udr = 1'b1;
      sr = 38'h11;
      tick();
      reset_n = 1'b0;
      #1;
      model_reset();
      check_val("rst_valid", cmd_if.cmd_valid, 1'b0);
      check_val("rst_jdo", cmd_if.jdo, 38'h0);
      check_val("rst_pending", cmd_pending, 1'b0);
      repeat (2) tick();
      cmd_if.cmd_ready = 1'b1;
      reset_n = 1'b1;
      lat = 0;
      for (int i = 1; i <= 10; i++) begin
         tick();
         if (cmd_if.cmd_valid && lat == 0) lat = i;
      end
      check_val("rst_release_lat", lat, 4);
      check_val("rst_release_jdo", cmd_if.jdo, 38'h11);
      vs_udr = 1'b0;
      repeat (2) tick();

      // Random strobes, data, back-pressure, clears and occasional resets.
      for (int c = 0; c < 3000; c++) begin
         if ($urandom_range(0, 5) == 0) vs_uir = ~vs_uir;
         if ($urandom_range(0, 3) == 0) vs_udr = ~vs_udr;
         if ($urandom_range(0, 7) == 0) ir_in = IR_W'($urandom);
         if ($urandom_range(0, 2) == 0) sr = {6'($urandom), 32'($urandom)};
         cmd_if.cmd_ready = ($urandom_range(0, 2) != 0);
         ovf_clr = ($urandom_range(0, 19) == 0);
         if ($urandom_range(0, 599) == 0) begin
            reset_n = 1'b0;
            #1;
            model_reset();
            compare_all();
            tick();
            reset_n = 1'b1;
         end
         tick();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/nios2_dbg_cmd_dispatch.md
Name: nios2_dbg_cmd_dispatch

Overview:
- System-clock half of the next-generation Nios II JTAG debug slave, parametrised in scan width, IR width and queue depth.
- Synchronises virtual-JTAG update-IR/update-DR strobes arriving asynchronously from the TCK domain and captures the IR and shift-register contents.
- Queues captured commands in a small FIFO, so back-to-back debugger scans are not lost while the CPU-side OCI logic is busy.
- Dispatches each command through a valid/ready handshake plus one-hot take_action/take_no_action pulses.

Parameters:
- SR_W, 38, shift-register / jdo width.
- IR_W, 2, virtual IR width; command decode space is 2**IR_W.
- ACT_BIT, 35, sr bit selecting action (1) vs no-action (0); must be < SR_W.
- SYNC_STAGES, 2, synchroniser flops on vs_uir/vs_udr; must be >= 2.
- FIFO_DEPTH, 4, command queue entries; power of two, >= 2.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- ir_in  in  IR_W  virtual IR from the TCK domain; quasi-static.
- sr  in  SR_W  TCK-domain shift register; stable >= SYNC_STAGES+2 clk after the vs_udr rise.
- vs_uir  in  1  update-IR strobe, asynchronous level.
- vs_udr  in  1  update-DR strobe, asynchronous level.
- cmd_ready  in  1  consumer accepts the current command.
- ovf_clr  in  1  clears the sticky overflow flag.
- jdo  out  SR_W  captured sr of the current command.
- cmd_ir  out  IR_W  IR of the current command.
- cmd_valid  out  1  jdo/cmd_ir valid; held until accepted.
- take_action  out  2**IR_W  one-hot pulse: command k with action bit = 1.
- take_no_action  out  2**IR_W  one-hot pulse: command k with action bit = 0.
- cmd_pending  out  1  FIFO non-empty.
- ovf  out  1  sticky: a command was dropped on a full FIFO.

Behaviour:
- Reset (async assert, sync deassert use): synchronisers, edge-detect history, FIFO pointers and count, ir_reg, jdo, cmd_ir and all outputs are 0.
- Edge detect: rise = last sync stage 1 and previous value 0.
  - Because history resets to 0, a strobe already high at reset release produces one edge after sync.
- uir rise: ir_reg <= ir_in.
- udr rise: push {ir_reg, sr} into the FIFO.
  - If uir and udr rises are detected in the same cycle, the pushed entry uses ir_in, not the old ir_reg.
- Pop condition: FIFO non-empty and (cmd_valid == 0 or cmd_ready == 1).
  - On pop, the output register loads jdo/cmd_ir and cmd_valid <= 1.
  - Else, if cmd_ready is 1, cmd_valid <= 0.
  - jdo and cmd_ir hold their value after acceptance; they are not cleared.
- Pulses: on the load edge, take_action[cmd_ir] <= jdo[ACT_BIT] and take_no_action[cmd_ir] <= ~jdo[ACT_BIT]; all other bits 0.
  - Pulses last exactly one cycle, the first cycle of cmd_valid for that command.
  - Back-to-back pops give back-to-back pulses.
- Latency: with FIFO empty, cmd_valid 0 and cmd_ready 1, cmd_valid rises at clock edge SYNC_STAGES+2, counted from the first edge sampling vs_udr high (push at edge SYNC_STAGES+1).
- Full FIFO:
  - A push with no pop in the same cycle is dropped and ovf <= 1.
  - Push and pop in the same cycle when full both succeed; count is unchanged.
- Empty FIFO: no pop; cmd_pending = (count != 0), registered alongside the count.
- ovf: ovf_clr clears it; a drop in the same cycle as ovf_clr wins (ovf stays 1).
- Pointers wrap modulo FIFO_DEPTH.
- Count is $clog2(FIFO_DEPTH)+1 bits and never exceeds FIFO_DEPTH.
- Reset mid-operation discards queued and current commands; no pulses are emitted during or at reset release.

Optional Feature:
- Macro: DBG_CMD_TIMESTAMP_EN.
- When defined:
  - Adds a 16-bit free-running counter (reset 0, wraps 0xFFFF->0).
  - Adds output cmd_ts[15:0].
  - Each FIFO entry stores the counter value at its push edge; cmd_ts loads with jdo.
- When undefined: no counter, no cmd_ts port, FIFO entries are IR_W+SR_W bits.

Test Plan:
- Reset, then ir scan 2'b01, then dr scan sr=38'h08_0000_1234 (bit 35 = 1), cmd_ready=1 -> cmd_valid rises at edge 4 after the udr sample; jdo=38'h08_0000_1234; cmd_ir=1; take_action=4'b0010 for one cycle; take_no_action=0.
- Dr scan with sr[35]=0 under ir 2'b11 -> take_no_action=4'b1000 pulse; take_action=0.
- cmd_ready=0, five dr scans with sr=1..5 -> first loads to output (jdo=1) and FIFO holds 2..5; ovf=0; then a sixth scan -> dropped, ovf=1. Raise cmd_ready -> jdo sequence 2,3,4,5; cmd_pending falls after the last pop. ovf_clr -> ovf=0.
- Hold cmd_ready=0 with cmd_valid=1 for 10 cycles -> jdo, cmd_ir and cmd_valid stable; only one pulse emitted.
- Full FIFO plus a udr rise in the same cycle as an accept -> both succeed; count stays 4; ovf stays 0.
- Assert reset_n=0 while 3 entries are queued and vs_udr=1 -> all outputs 0. Release with vs_udr=1 -> one push after sync (edge detected from reset history 0). With DBG_CMD_TIMESTAMP_EN, cmd_ts equals the counter value at the push edge.
